// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, receiver states and status packing
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_ODD  = 2'd1,
      PARITY_EVEN = 2'd2
   } parity_t;

   typedef enum logic {
      STOP_1 = 1'b0,
      STOP_2 = 1'b1
   } stop_bits_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BREAK_WAIT
   } rx_state_t;

   typedef struct packed {
      logic parity_err;
      logic frame_err;
      logic brk;
   } uart_rx_status_t;

   localparam int UART_MIN_DATA_BITS = 5;

   // Keeps an out-of-range data-bit request inside the legal window so the
   // bit counter can never run past the shift register.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
      if (int'(req) < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
      if (int'(req) > max_bits)           return 4'(max_bits);
      return req;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, oversample counter and 3-tap majority vote
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic hold,
   output logic rx_s,
   output logic bit_vote,
   output logic vote_strobe,
   output logic window_end
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] TAP_A = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] TAP_B = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] TAP_C = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);

   logic          rx_meta;
   logic [CW-1:0] cnt;
   logic          samp_a;
   logic          samp_b;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Position within the current bit; parked at 0 while idle so the first
   // window starts on the edge the start bit is seen. Power-of-two wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (hold) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   // First two vote taps; the third tap is the live rx_s at TAP_C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (cnt == TAP_A) samp_a <= rx_s;
         if (cnt == TAP_B) samp_b <= rx_s;
      end
   end

   // Majority of the three taps, valid while the third tap is present.
   always_comb begin
      bit_vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
      vote_strobe = !hold && (cnt == TAP_C);
      window_end  = !hold && (cnt == LAST);
   end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampled UART receiver with single-entry output register
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE    = 16,
   parameter int MAX_DATA_BITS = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   input  logic                     rx_en,
   input  logic [3:0]               cfg_data_bits,
   input  parity_t                  cfg_parity,
   input  stop_bits_t               cfg_stop_bits,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [MAX_DATA_BITS-1:0] m_data,
   output logic                     m_parity_err,
   output logic                     m_frame_err,
   output logic                     m_break,
   output logic                     overrun,
   output logic                     busy
);

   rx_state_t                state, state_n;
   logic [3:0]               bit_cnt, bit_cnt_n;
   logic [MAX_DATA_BITS-1:0] shreg, shreg_n;
   logic [3:0]               nbits_q, nbits_n;
   parity_t                  par_q, par_n;
   stop_bits_t               stop_q, stop_n;
   logic                     par_err, par_err_n;
   logic                     frame_err, frame_err_n;
   logic                     saw_one, saw_one_n;

   logic                     rx_s;
   logic                     bit_vote;
   logic                     vote_strobe;
   logic                     window_end;

   logic                     done;
   logic                     brk_now;
   logic [MAX_DATA_BITS-1:0] word_data;
   uart_rx_status_t          word_status;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .hold        (state == S_IDLE),
      .rx_s        (rx_s),
      .bit_vote    (bit_vote),
      .vote_strobe (vote_strobe),
      .window_end  (window_end)
   );

   // Frame state and the per-frame configuration snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         nbits_q   <= 4'd8;
         par_q     <= PARITY_NONE;
         stop_q    <= STOP_1;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         saw_one   <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         nbits_q   <= nbits_n;
         par_q     <= par_n;
         stop_q    <= stop_n;
         par_err   <= par_err_n;
         frame_err <= frame_err_n;
         saw_one   <= saw_one_n;
      end
   end

   // Next-state logic; a frame completes on the final stop vote, not at its window end.
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      nbits_n     = nbits_q;
      par_n       = par_q;
      stop_n      = stop_q;
      par_err_n   = par_err;
      frame_err_n = frame_err;
      saw_one_n   = saw_one;
      done        = 1'b0;
      brk_now     = 1'b0;

      case (state)
         S_IDLE: begin
            if (rx_en && !rx_s) begin
               state_n     = S_START;
               bit_cnt_n   = '0;
               shreg_n     = '0;
               nbits_n     = clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
               par_n       = cfg_parity;
               stop_n      = cfg_stop_bits;
               par_err_n   = 1'b0;
               frame_err_n = 1'b0;
               saw_one_n   = 1'b0;
            end
         end
         S_START: begin
            if (vote_strobe && bit_vote) state_n = S_IDLE;
            else if (window_end)         state_n = S_DATA;
         end
         S_DATA: begin
            if (vote_strobe) begin
               for (int i = 0; i < MAX_DATA_BITS; i++) begin
                  if (bit_cnt == 4'(i)) shreg_n[i] = bit_vote;
               end
               saw_one_n = saw_one | bit_vote;
            end
            if (window_end) begin
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == nbits_q - 4'd1) begin
                  state_n = (par_q != PARITY_NONE) ? S_PARITY : S_STOP1;
               end
            end
         end
         S_PARITY: begin
            if (vote_strobe) begin
               // Odd parity expects the XOR over data and parity bit to be 1.
               par_err_n = (^shreg) ^ bit_vote ^ (par_q == PARITY_ODD);
               saw_one_n = saw_one | bit_vote;
            end
            if (window_end) state_n = S_STOP1;
         end
         S_STOP1, S_STOP2: begin
            if (vote_strobe) begin
               frame_err_n = frame_err | ~bit_vote;
               saw_one_n   = saw_one | bit_vote;
               if (state == S_STOP2 || stop_q == STOP_1) begin
                  done    = 1'b1;
                  brk_now = ~(saw_one | bit_vote);
                  state_n = brk_now ? S_BREAK_WAIT : S_IDLE;
               end
            end else if (window_end && state == S_STOP1) begin
               state_n = S_STOP2;
            end
         end
         S_BREAK_WAIT: begin
            if (rx_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      word_data              = brk_now ? '0 : shreg;
      word_status.parity_err = par_err;
      word_status.frame_err  = frame_err_n;
      word_status.brk        = brk_now;
   end

   // Output holding register: a handoff in the completion cycle wins over overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_parity_err <= 1'b0;
         m_frame_err  <= 1'b0;
         m_break      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done && (!m_valid || m_ready)) begin
            m_valid      <= 1'b1;
            m_data       <= word_data;
            m_parity_err <= word_status.parity_err;
            m_frame_err  <= word_status.frame_err;
            m_break      <= word_status.brk;
         end else if (done) begin
            overrun <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Second-generation UART receiver for the peripheral UART path. It synchronises the asynchronous `rx` pin and oversamples each bit with a 3-sample majority vote. It rejects glitch start bits, supports 5–9 data bits, optional parity and 1/2 stop bits, and flags parity, framing and break conditions. Each received word, with its status flags, is presented on a single-entry valid/ready output register that detects overrun; this feeds the RX FIFO.

## Interface
- `OVERSAMPLE`, default 16: clk cycles per bit. Power of two, ≥ 8.
- `MAX_DATA_BITS`, default 9: width of `m_data`. Legal range 5..9.
- `clk` input, 1: sample clock, `OVERSAMPLE` × baud.
- `rst` input, 1: asynchronous, active-high reset; clock is `clk`.
- `rx` input, 1: serial line, idle high, asynchronous to `clk`.
- `rx_en` input, 1: enables start detection.
- `cfg_data_bits` input, 4: data bits per frame, 5..`MAX_DATA_BITS`.
- `cfg_parity` input, `parity_t`: NONE / ODD / EVEN.
- `cfg_stop_bits` input, `stop_bits_t`: 1 or 2 stop bits.
- `m_valid` output, 1: output word valid.
- `m_ready` input, 1: consumer accepts the word.
- `m_data` output, `MAX_DATA_BITS`: received word, LSB-aligned, unused upper bits 0.
- `m_parity_err` output, 1: parity mismatch for the presented word.
- `m_frame_err` output, 1: a stop bit was sampled 0.
- `m_break` output, 1: the word is a break condition.
- `overrun` output, 1: one-cycle pulse when a completed word is dropped.
- `busy` output, 1: a frame is in progress.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1), giving `rx_s`. All logic uses `rx_s`.
- Majority vote: for each bit, samples are taken at counter values M−1, M and M+1, where M = `OVERSAMPLE`/2. Bit value = at least 2 of the 3 samples are 1.
- State machine: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK_WAIT.
- S_IDLE:
  - On `rx_en` = 1 and `rx_s` = 0: latch `cfg_*`, clear the bit counter and the shift register, go to S_START.
  - If `rx_en` = 0, stay in S_IDLE.
  - Config changes and `rx_en` deassertion in mid-frame have no effect on the frame in progress.
- S_START: if the start-bit vote is 1 (false start), return to S_IDLE with no output. Otherwise, at the window end go to S_DATA.
- S_DATA: bits arrive LSB first. After the last data bit, go to S_PARITY if parity is enabled, otherwise to S_STOP1.
- S_PARITY: parity error = XOR(data, parity bit) is not 0 (EVEN) or not 1 (ODD).
- S_STOP1:
  - A vote of 0 sets frame error.
  - With 2 stop bits, go to S_STOP2 at the window end.
  - Otherwise the frame completes at vote time.
  - S_STOP2 is identical to S_STOP1 and is always the final stop bit.
- Completion at final stop-bit vote:
  - Deliver the word and return to S_IDLE, not waiting for the window end, so back-to-back frames resynchronise on the next start edge.
  - Break: all data, parity and stop votes are 0. Deliver with `m_data` = 0, `m_break` = 1 and `m_frame_err` = 1, then go to S_BREAK_WAIT.
  - S_BREAK_WAIT: stay until `rx_s` = 1, then go to S_IDLE.
- Output register:
  - Loads data and flags when empty, or when `m_valid` & `m_ready` in the same cycle as completion. The handoff takes priority, so no overrun is reported in that case.
  - If `m_valid` & !`m_ready` at completion: the new word is discarded, the held word is kept, and `overrun` pulses for 1 cycle.
  - `m_valid` stays high and `m_data`/flags stay stable until accepted.
- `busy` = state not in {S_IDLE}. It stays high during S_BREAK_WAIT.
- `rst` mid-frame: everything returns to reset immediately, and any held word is lost.
- Reset values: `m_valid` 0, `m_data` 0, all flags 0, `overrun` 0, `busy` 0, state S_IDLE.

## Timing
- t0 is the edge at which S_IDLE sees `rx_s` = 0; the pin fell 2 edges earlier.
- Bit k (start = 0) occupies counter window [t0+1+k·OS, t0+(k+1)·OS]. The vote completes at sample M+1.
- `m_valid` rises at edge t0 + k_last·OS + M + 2, where k_last is the index of the final stop bit.
  - 8N1, OS = 16: k_last = 9, so `m_valid` rises at t0+154.
- The earliest next start detection is 1 cycle after return to S_IDLE.
- Accept occurs on the edge where `m_valid` & `m_ready`; `m_valid` drops the following cycle unless reloaded.

## Structure
- The existing `uart_pkg` gains:
  - `rx_state_t` for the states above;
  - `uart_rx_status_t` packing the parity, frame and break flags;
  - `UART_MIN_DATA_BITS` = 5.
- `parity_t` and `stop_bits_t` are reused unchanged from `uart_pkg`.
- One sub-module, `uart_rx_sampler`: 2-flop synchroniser, oversample counter, 3-tap majority vote. It outputs `rx_s`, `bit_vote`, `vote_strobe` and `window_end`.

## Test plan
- 8N1, OS = 16, send 0xA5 with `m_ready` = 1 → `m_valid` at t0+154, `m_data` = 0x0A5, all flags 0.
- 9E2, send 0x1C3 with a wrong parity bit → `m_data` = 0x1C3, `m_parity_err` = 1. Repeat with a 0 second stop bit → `m_frame_err` = 1.
- Start glitch 5 cycles low → no `m_valid`, `busy` returns to 0 after the start window. Single-sample glitch inside a data bit → word correct.
- Two back-to-back 8N1 frames 0x11, 0x22 with `m_ready` = 0 → `m_data` holds 0x011, `overrun` pulses once. Raise `m_ready` exactly at the second completion → 0x022 loaded, no overrun.
- `rx` held low 3 frame times → one word with `m_break` = 1 and `m_data` = 0, `busy` = 1 until the line rises, then no further words.
- Assert `rst` mid-data-bit → all outputs 0 in the same cycle. A clean 0x5A frame afterwards is received correctly.
